// File: rtl/fetch_ifid.sv
// Fetch stage and IF/ID pipeline register: PC, redirect/stall handling, source-register decode.
// Optional macro HALT_DETECT_EN: freeze fetch once a valid HALT reaches IF/ID.
module fetch_ifid #(
  parameter int                      PC_WIDTH    = 16,
  parameter int                      INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 16'h0800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallCtrl,
  input  logic                   jumpFlush,
  input  logic [PC_WIDTH-1:0]    jumpTarget_IDEX,
  input  logic                   takeBranch_EXMEM,
  input  logic [PC_WIDTH-1:0]    branchTarget_EXMEM,
  input  logic [INSTR_WIDTH-1:0] instr_mem,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INSTR_WIDTH-1:0] instr_IFID,
  output logic [PC_WIDTH-1:0]    pcPlus2_IFID,
  output logic                   valid_IFID,
  output logic [2:0]             Rd1Addr_IFID,
  output logic [2:0]             Rd2Addr_IFID,
  output logic                   halted
);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pcp2_q, pcp2_d;
  logic                   valid_q, valid_d;
  logic                   halted_q, halted_d;

  logic [PC_WIDTH-1:0]    pc_plus2;
  logic [PC_WIDTH-1:0]    redirect_tgt;
  logic                   redirect;
  logic                   is_halt;

  assign pc_plus2 = pc_q + PC_WIDTH'(2);
  assign redirect = takeBranch_EXMEM | jumpFlush;
  // The older branch in EX/MEM overrides a jump from ID/EX.
  assign redirect_tgt = (takeBranch_EXMEM ? branchTarget_EXMEM : jumpTarget_IDEX)
                        & ~PC_WIDTH'(1);
  assign is_halt = (instr_mem[INSTR_WIDTH-1 -: 5] == 5'b00000);

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcp2_d   = pcp2_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_tgt;
      instr_d  = NOP_INSTR;
      pcp2_d   = '0;
      valid_d  = 1'b0;
      halted_d = 1'b0;
    end else if (!stallCtrl && !halted_q) begin
      pc_d    = pc_plus2;
      instr_d = instr_mem;
      pcp2_d  = pc_plus2;
      valid_d = 1'b1;
`ifdef HALT_DETECT_EN
      halted_d = is_halt;
`endif
    end
`ifndef HALT_DETECT_EN
    halted_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pcp2_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcp2_q   <= pcp2_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign imem_addr    = pc_q;
  assign instr_IFID   = instr_q;
  assign pcPlus2_IFID = pcp2_q;
  assign valid_IFID   = valid_q;
  assign Rd1Addr_IFID = instr_q[10:8];
  assign Rd2Addr_IFID = instr_q[7:5];
  assign halted       = halted_q;

`ifndef HALT_DETECT_EN
  logic unused_ok;
  assign unused_ok = is_halt;
`endif

endmodule
